// File: rtl/class_pkg.sv
// class_pkg: shared class code types and constants for the class encoder/histogram stages
package class_pkg;
    typedef logic [1:0] class_t;
    localparam class_t CLASS_0 = 2'd0;
    localparam class_t CLASS_1 = 2'd1;
    localparam class_t CLASS_2 = 2'd2;
    localparam class_t CLASS_3 = 2'd3;
    localparam int NUM_CLASSES = 4;
    typedef enum logic {ACC, HOLD} hist_state_t;
endpackage

// File: rtl/class_histogram_acc.sv
// class_histogram_acc: one per-class occurrence counter with clear and increment enables
module class_histogram_acc #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    always_ff @(posedge clk)
        if (rst || clr) cnt <= '0;
        else if (inc) cnt <= cnt + W'(1);
endmodule

// File: rtl/class_histogram.sv
// class_histogram: per-window class counts published through a valid/ready snapshot
// Optional argmax output 'top' enabled by CLASS_HISTOGRAM_ARGMAX_EN.
module class_histogram
    import class_pkg::*;
#(
    parameter  int WIN   = 16,
    localparam int CNT_W = $clog2(WIN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       y,
    input  logic             y_valid,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2,
    output logic [CNT_W-1:0] cnt3,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             overrun
`ifdef CLASS_HISTOGRAM_ARGMAX_EN
    ,
    output logic [1:0]       top
`endif
);
    logic [NUM_CLASSES-1:0] hit;
    logic [CNT_W-1:0] acc  [NUM_CLASSES];
    logic [CNT_W-1:0] nxt  [NUM_CLASSES];
    logic [CNT_W-1:0] snap [NUM_CLASSES];
    logic [CNT_W-1:0] smp;
    logic win_end, load, ovf;
    hist_state_t state, state_n;

    assign hit = {y == CLASS_3, y == CLASS_2, y == CLASS_1, y == CLASS_0} & {NUM_CLASSES{y_valid}};
    assign win_end = y_valid && smp == CNT_W'(WIN - 1);

    // nxt folds in the current sample so the snapshot includes the window's last sample
    for (genvar i = 0; i < NUM_CLASSES; i++) begin : g_acc
        class_histogram_acc #(.W(CNT_W)) u_acc (
            .clk(clk),
            .rst(rst),
            .clr(win_end),
            .inc(hit[i]),
            .cnt(acc[i])
        );
        assign nxt[i] = acc[i] + CNT_W'(hit[i]);
    end

    always_ff @(posedge clk)
        if (rst || win_end) smp <= '0;
        else if (y_valid) smp <= smp + CNT_W'(1);

    always_ff @(posedge clk)
        if (rst) state <= ACC;
        else state <= state_n;

    always_comb begin
        load    = win_end && (state == ACC || res_ready);
        ovf     = win_end && state == HOLD && !res_ready;
        state_n = load ? HOLD : (state == HOLD && res_ready) ? ACC : state;
    end

    always_ff @(posedge clk)
        if (rst) begin
            for (int k = 0; k < NUM_CLASSES; k++) snap[k] <= '0;
            overrun <= 1'b0;
        end else begin
            if (load) for (int k = 0; k < NUM_CLASSES; k++) snap[k] <= nxt[k];
            overrun <= overrun | ovf;
        end

    assign res_valid = state == HOLD;
    assign cnt0 = snap[0];
    assign cnt1 = snap[1];
    assign cnt2 = snap[2];
    assign cnt3 = snap[3];

`ifdef CLASS_HISTOGRAM_ARGMAX_EN
    logic [1:0] amax;
    logic [CNT_W-1:0] mx;

    // strict compare keeps the lowest index on ties
    always_comb begin
        amax = CLASS_0;
        mx   = nxt[0];
        for (int k = 1; k < NUM_CLASSES; k++)
            if (nxt[k] > mx) begin
                mx   = nxt[k];
                amax = 2'(k);
            end
    end

    always_ff @(posedge clk)
        if (rst) top <= CLASS_0;
        else if (load) top <= amax;
`endif
endmodule

// File: tb/tb_class_histogram.sv
// tb_class_histogram: directed stimulus with a per-cycle reference model and literal spot checks
module tb_class_histogram;
    localparam int WIN = 16;
    localparam int CW  = $clog2(WIN + 1);

    logic clk = 1'b0;
    logic rst, y_valid, res_ready, res_valid, overrun;
    logic [1:0] y;
    logic [CW-1:0] cnt0, cnt1, cnt2, cnt3;
`ifdef CLASS_HISTOGRAM_ARGMAX_EN
    logic [1:0] top;
`endif

    class_histogram #(.WIN(WIN)) dut (
        .clk(clk),
        .rst(rst),
        .y(y),
        .y_valid(y_valid),
        .cnt0(cnt0),
        .cnt1(cnt1),
        .cnt2(cnt2),
        .cnt3(cnt3),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .overrun(overrun)
`ifdef CLASS_HISTOGRAM_ARGMAX_EN
        ,
        .top(top)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    bit go = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int argmax(input int c[4]);
        int b = 0;
        for (int k = 1; k < 4; k++) if (c[k] > c[b]) b = k;
        return b;
    endfunction

    // reference: counts per window, a single-entry result slot, sticky drop flag
    int m_acc[4], m_snap[4], fin[4];
    int m_n;
    bit m_valid, m_over, ended, take;

    always @(posedge clk) begin
        if (rst) begin
            m_acc = '{0, 0, 0, 0};
            m_snap = '{0, 0, 0, 0};
            m_n = 0;
            m_valid = 0;
            m_over = 0;
        end else begin
            ended = 0;
            take = m_valid && res_ready;
            if (y_valid) begin
                m_acc[int'(y)]++;
                m_n++;
                if (m_n == WIN) begin
                    ended = 1;
                    fin = m_acc;
                    m_acc = '{0, 0, 0, 0};
                    m_n = 0;
                end
            end
            if (ended && (!m_valid || take)) begin
                m_snap = fin;
                m_valid = 1;
            end else begin
                if (ended) m_over = 1;
                if (take) m_valid = 0;
            end
        end
    end

    always @(negedge clk)
        if (go) begin
            chk("res_valid", 32'(res_valid), 32'(m_valid));
            chk("overrun", 32'(overrun), 32'(m_over));
            if (m_valid) begin
                chk("cnt0", 32'(cnt0), m_snap[0]);
                chk("cnt1", 32'(cnt1), m_snap[1]);
                chk("cnt2", 32'(cnt2), m_snap[2]);
                chk("cnt3", 32'(cnt3), m_snap[3]);
                chk("sum", 32'(cnt0) + 32'(cnt1) + 32'(cnt2) + 32'(cnt3), WIN);
`ifdef CLASS_HISTOGRAM_ARGMAX_EN
                chk("top", 32'(top), argmax(m_snap));
`endif
            end
        end

    task automatic cyc(input bit v, input int yy, input bit rdy);
        y_valid = v;
        y = 2'(yy);
        res_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic do_rst();
        rst = 1;
        cyc(1, 0, 0);
        rst = 0;
    endtask

    initial begin
        rst = 1;
        y_valid = 1;
        y = 0;
        res_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        go = 1;
        chk("rst res_valid", 32'(res_valid), 0);
        chk("rst cnt0", 32'(cnt0), 0);
        chk("rst cnt3", 32'(cnt3), 0);
        chk("rst overrun", 32'(overrun), 0);
`ifdef CLASS_HISTOGRAM_ARGMAX_EN
        chk("rst top", 32'(top), 0);
`endif
        rst = 0;

        for (int i = 0; i < 16; i++) cyc(1, i % 4, 1);
        chk("even valid", 32'(res_valid), 1);
        chk("even cnt0", 32'(cnt0), 4);
        chk("even cnt1", 32'(cnt1), 4);
        chk("even cnt2", 32'(cnt2), 4);
        chk("even cnt3", 32'(cnt3), 4);
`ifdef CLASS_HISTOGRAM_ARGMAX_EN
        chk("even top", 32'(top), 0);
`endif
        cyc(0, 0, 1);
        chk("even consumed", 32'(res_valid), 0);

        for (int i = 0; i < 32; i++) begin
            if (i == 31) chk("gap early valid", 32'(res_valid), 0);
            cyc(i % 2 == 1, 2, 1);
        end
        chk("gap valid", 32'(res_valid), 1);
        chk("gap cnt2", 32'(cnt2), 16);
        chk("gap cnt0", 32'(cnt0), 0);
        cyc(0, 0, 1);

        for (int i = 0; i < 16; i++) cyc(1, 1, 0);
        chk("bp valid", 32'(res_valid), 1);
        chk("bp cnt1", 32'(cnt1), 16);
        chk("bp no overrun", 32'(overrun), 0);
        for (int i = 0; i < 16; i++) cyc(1, 3, 0);
        chk("bp overrun", 32'(overrun), 1);
        chk("bp held cnt1", 32'(cnt1), 16);
        chk("bp held cnt3", 32'(cnt3), 0);
        cyc(0, 0, 1);
        chk("bp consumed", 32'(res_valid), 0);
        cyc(0, 0, 1);
        chk("bp sticky", 32'(overrun), 1);

        do_rst();
        chk("rst clears overrun", 32'(overrun), 0);
        for (int i = 0; i < 16; i++) cyc(1, 0, 0);
        for (int i = 0; i < 16; i++) cyc(1, 2, i == 15);
        chk("sim valid", 32'(res_valid), 1);
        chk("sim cnt2", 32'(cnt2), 16);
        chk("sim cnt0", 32'(cnt0), 0);
        chk("sim overrun", 32'(overrun), 0);
        cyc(0, 0, 1);

        for (int i = 0; i < 7; i++) cyc(1, 0, 1);
        do_rst();
        for (int i = 0; i < 16; i++) cyc(1, 3, 1);
        chk("mid cnt3", 32'(cnt3), 16);
        chk("mid cnt0", 32'(cnt0), 0);
`ifdef CLASS_HISTOGRAM_ARGMAX_EN
        chk("mid top", 32'(top), 3);
`endif
        cyc(0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/class_histogram.md
Name: class_histogram

Overview:
- Downstream consumer of the 3-bit-to-2-bit class encoder stage.
- Takes the encoder's 2-bit class code y, one sample per valid cycle, and counts the occurrences of each of the 4 classes over a fixed window of WIN samples.
- At each window end it publishes a snapshot of the four counts through a valid/ready handshake.
- Sits between the encoder stage and the statistics/readout logic.

Parameters:
- WIN, 16, samples per window; legal range 2..255.
- CNT_W, $clog2(WIN+1) (localparam, derived), width of each class count. Holds the value WIN without overflow.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- y  input  2  class code from the encoder stage
- y_valid  input  1  y is a valid sample this cycle; the block is always ready to accept it
- cnt0  output  CNT_W  snapshot count of class 0
- cnt1  output  CNT_W  snapshot count of class 1
- cnt2  output  CNT_W  snapshot count of class 2
- cnt3  output  CNT_W  snapshot count of class 3
- res_valid  output  1  snapshot available
- res_ready  input  1  consumer accepts the snapshot
- overrun  output  1  sticky: a completed window was dropped

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: all outputs 0; internal accumulators 0; sample counter 0; state ACC.
- Accumulation:
  - Each cycle with y_valid=1, accumulator acc[y] increments by 1.
  - The sample counter smp increments by 1.
  - y is ignored when y_valid=0.
- Window end: a cycle where y_valid=1 and smp==WIN-1.
  - Snapshot = accumulators including the current sample.
  - Accumulators and smp clear to 0 in the same edge, so there is no dead cycle.
  - The next sample begins the new window.
- Publish latency: snapshot appears on cnt0..cnt3, with res_valid=1, on the cycle after the last sample of the window.
- Handshake:
  - res_valid stays high until a cycle with res_valid && res_ready.
  - cnt0..cnt3 are stable while res_valid=1 and not consumed.
- State machine:
  - ACC: res_valid=0. On window end, load snapshot and go to HOLD.
  - HOLD: res_valid=1.
    - res_ready=1 and no window end: go to ACC.
    - res_ready=1 and window end in the same cycle: load the new snapshot and stay in HOLD (res_valid stays 1).
    - res_ready=0 and window end: the new snapshot is discarded, the old one is kept, overrun is set, and the state stays HOLD.
- Invariant: cnt0+cnt1+cnt2+cnt3 == WIN for every published snapshot.
- overrun: sticky; cleared only by rst.
- rst mid-window: the partial window is discarded; counting restarts from 0.
- rst in HOLD: res_valid drops in the following cycle; the snapshot is lost.
- Arithmetic: unsigned. Accumulators cannot exceed WIN, so no saturation logic is needed.

Optional Feature:
- Macro: CLASS_HISTOGRAM_ARGMAX_EN.
- When defined:
  - Extra output port top  output  2  = index of the largest snapshot count.
  - Ties resolve to the lowest index.
  - Registered together with cnt0..cnt3 and valid under the same res_valid; reset value 0.
- When undefined: port absent, no comparator logic.

Decomposition:
- Shared package class_pkg holds:
  - typedef class_t (logic [1:0]);
  - constants CLASS_0..CLASS_3 = 2'd0..2'd3;
  - NUM_CLASSES = 4.
- One sub-module: class_histogram_acc, a single per-class accumulator with clear and increment enables, instantiated 4 times.
- FSM, sample counter and snapshot registers stay in the top.

Test Plan:
- Reset: assert rst 2 cycles with y_valid=1 -> all outputs 0, no counting during reset.
- WIN=16, feed y=0,1,2,3 repeated ×4 with y_valid=1, res_ready=1 -> one cycle after the 16th sample: res_valid=1, cnt0..3=4,4,4,4; consumed the next cycle, returns to ACC.
- Gapped input: 16 samples all y=2, with y_valid toggling every other cycle -> cnt2=16, others 0; res_valid appears only after the 16th valid sample.
- Back-pressure: res_ready=0 across two full windows (first all y=1, second all y=3) -> held snapshot cnt1=16, overrun=1; after res_ready=1 the held data is consumed, overrun stays 1 until rst.
- Simultaneous: res_ready=1 in the exact cycle the next window ends -> the new snapshot loads, res_valid stays 1 with no gap, overrun stays 0.
- Mid-window reset: 7 samples of y=0, rst for 1 cycle, then 16 samples of y=3 -> snapshot cnt3=16, cnt0=0. With CLASS_HISTOGRAM_ARGMAX_EN: top=3; for a 4,4,4,4 window, top=0.
